lnrv_exu_flush_arb: RTL and testbench
=====================================

// Module: lnrv_exu_flush_arb
// PURPOSE
//   Shares the single IFU pipeline-flush port among the four EXU flush sources:
//   debug entry, synchronous exception, interrupt and branch/jump mispredict.
//   Picks one source by fixed priority and registers its target operands.
//   Holds the request stable until the IFU acks it, then returns the ack to the winning source.
//   Sits between the EXU trap/irq/bjp units and the IFU flush interface.
// PARAMETERS
//   XLEN    32  width of flush target operands
//   CNT_W   16  width of saturating completed-flush counter
// PORTS
//   clk                 in   1     core clock
//   reset_n             in   1     asynchronous active-low reset
//   dbg_flush_req       in   1     debug-entry flush request (priority 0, highest)
//   dbg_flush_pc_op1/2  in   XLEN  debug target operands
//   dbg_flush_ack       out  1     ack pulse to debug source
//   exc_flush_req/ack, exc_flush_pc_op1/2   same, exception source (priority 1)
//   irq_flush_req/ack, irq_flush_pc_op1/2   same, interrupt source (priority 2)
//   bjp_flush_req/ack, bjp_flush_pc_op1/2   same, branch/jump source (priority 3, lowest)
//   pipe_flush_req      out  1     flush request to IFU
//   pipe_flush_ack      in   1     IFU accepts flush
//   pipe_flush_pc_op1   out  XLEN  target op1; IFU target = op1 + op2
//   pipe_flush_pc_op2   out  XLEN  target op2
//   pipe_flush_src      out  2     granted source: 0 dbg, 1 exc, 2 irq, 3 bjp
//   flush_busy          out  1     arbiter holding a request (state REQ)
//   flush_cnt           out  CNT_W completed flushes, saturating
// BEHAVIOUR
//   Reset (async, reset_n=0)
//     - State goes to IDLE.
//     - pipe_flush_req, pipe_flush_pc_op1/op2, pipe_flush_src, flush_busy and flush_cnt all go to 0.
//     - All *_flush_ack go to 0.
//   FSM IDLE
//     - If any *_flush_req=1: capture the highest-priority requester's op1/op2 and id into registers; go to REQ.
//     - pipe_flush_req=1 from the next cycle, so request-to-output latency is 1 cycle.
//     - Otherwise stay in IDLE.
//   FSM REQ
//     - pipe_flush_req=1 and flush_busy=1.
//     - pipe_flush_pc_op1/op2 and pipe_flush_src are stable and do not follow source input changes.
//     - On pipe_flush_ack=1 (handshake cycle):
//       - <src>_flush_ack=1 combinationally for the granted source only.
//       - flush_cnt increments; it holds at all-ones once saturated.
//       - Next state is IDLE.
//     - No preemption: a higher-priority request arriving in REQ waits for the current handshake.
//   Back-to-back
//     - Leaving REQ always passes through one IDLE cycle.
//     - Pending requests are re-arbitrated there; min spacing between handshakes is 2 cycles.
//   Source contract
//     - A source keeps req asserted until it sees its ack.
//     - If a source drops req while in REQ, the captured flush still completes and the ack still pulses.
//     - The source qualifies the ack with its own req (e.g. an irq CSR commit uses req & ack).
//   Other rules
//     - pipe_flush_ack while IDLE is ignored: no ack is returned and flush_cnt does not change.
//     - Operands pass unmodified; there is no arithmetic on them.
//     - pipe_flush_req never deasserts in REQ without an ack.
// TESTING
//   1. irq_flush_req=1 with op1=0x8000_0100, op2=0 at cycle 0, ack at cycle 1
//      -> pipe_flush_req=1 at cycle 1, src=2, op1=0x8000_0100.
//      -> irq_flush_ack=1 in cycle 1 only; flush_cnt=1; IDLE at cycle 2.
//   2. dbg and bjp both req at cycle 0, ack held 1
//      -> dbg granted (src=0) and acked at cycle 1.
//      -> IDLE at cycle 2; bjp src=3 at cycle 3; bjp acked at cycle 3.
//   3. exc granted with op1=0x100; exc changes op1 to 0x200 and ack is delayed 5 cycles
//      -> outputs stay op1=0x100, src=1 until the ack cycle.
//   4. bjp granted, then bjp_flush_req drops before ack
//      -> pipe_flush_req stays 1; bjp_flush_ack pulses on ack; flush_cnt increments.
//   5. reset_n=0 asserted mid-REQ, asynchronous to clk
//      -> pipe_flush_req, flush_busy, flush_cnt and all acks are 0 immediately; IDLE after release.
//   6. CNT_W=2 with 5 handshakes -> flush_cnt=3 and stays 3; pipe_flush_ack while IDLE -> no ack, no change.

Source files
------------

// File: rtl/lnrv_exu_flush_arb.sv
// lnrv_exu_flush_arb: fixed-priority arbiter sharing the IFU flush port among dbg/exc/irq/bjp sources
module lnrv_exu_flush_arb #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dbg_flush_req,
  input  logic [XLEN-1:0]  dbg_flush_pc_op1,
  input  logic [XLEN-1:0]  dbg_flush_pc_op2,
  output logic             dbg_flush_ack,
  input  logic             exc_flush_req,
  input  logic [XLEN-1:0]  exc_flush_pc_op1,
  input  logic [XLEN-1:0]  exc_flush_pc_op2,
  output logic             exc_flush_ack,
  input  logic             irq_flush_req,
  input  logic [XLEN-1:0]  irq_flush_pc_op1,
  input  logic [XLEN-1:0]  irq_flush_pc_op2,
  output logic             irq_flush_ack,
  input  logic             bjp_flush_req,
  input  logic [XLEN-1:0]  bjp_flush_pc_op1,
  input  logic [XLEN-1:0]  bjp_flush_pc_op2,
  output logic             bjp_flush_ack,
  output logic             pipe_flush_req,
  input  logic             pipe_flush_ack,
  output logic [XLEN-1:0]  pipe_flush_pc_op1,
  output logic [XLEN-1:0]  pipe_flush_pc_op2,
  output logic [1:0]       pipe_flush_src,
  output logic             flush_busy,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t           r_state;
  logic             r_req;
  logic [1:0]       r_src;
  logic [XLEN-1:0]  r_op1;
  logic [XLEN-1:0]  r_op2;
  logic [CNT_W-1:0] r_cnt;
  logic             w_any;
  logic             w_hs;
  logic [1:0]       w_src;
  logic [XLEN-1:0]  w_op1;
  logic [XLEN-1:0]  w_op2;
  // fixed priority pick: dbg > exc > irq > bjp
  always_comb begin
    w_any = dbg_flush_req | exc_flush_req | irq_flush_req | bjp_flush_req;
    w_src = dbg_flush_req ? 2'd0 : exc_flush_req ? 2'd1 : irq_flush_req ? 2'd2 : 2'd3;
    w_op1 = dbg_flush_req ? dbg_flush_pc_op1 : exc_flush_req ? exc_flush_pc_op1 :
            irq_flush_req ? irq_flush_pc_op1 : bjp_flush_pc_op1;
    w_op2 = dbg_flush_req ? dbg_flush_pc_op2 : exc_flush_req ? exc_flush_pc_op2 :
            irq_flush_req ? irq_flush_pc_op2 : bjp_flush_pc_op2;
  end
  // ack only counts while a request is held, so an IDLE ack is ignored
  assign w_hs              = r_req & pipe_flush_ack;
  assign dbg_flush_ack     = w_hs & (r_src == 2'd0);
  assign exc_flush_ack     = w_hs & (r_src == 2'd1);
  assign irq_flush_ack     = w_hs & (r_src == 2'd2);
  assign bjp_flush_ack     = w_hs & (r_src == 2'd3);
  assign pipe_flush_req    = r_req;
  assign flush_busy        = r_req;
  assign pipe_flush_pc_op1 = r_op1;
  assign pipe_flush_pc_op2 = r_op2;
  assign pipe_flush_src    = r_src;
  assign flush_cnt         = r_cnt;
  // capture winner in IDLE, hold until handshake, always return through IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_src   <= 2'd0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_state <= REQ;
        r_req   <= 1'b1;
        r_src   <= w_src;
        r_op1   <= w_op1;
        r_op2   <= w_op2;
      end
    end else if (pipe_flush_ack) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, ~&r_cnt};
    end
  end
endmodule

// File: tb/tb_lnrv_exu_flush_arb.sv
// tb_lnrv_exu_flush_arb: randomized check of the flush arbiter against a transaction-level model
module tb_lnrv_exu_flush_arb;
  localparam int XLEN = 32;
  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      req = '0;
  logic [XLEN-1:0] op1 [4];
  logic [XLEN-1:0] op2 [4];
  logic            pack = 1'b0;
  wire             a_preq, a_busy, b_preq, b_busy;
  wire [XLEN-1:0]  a_op1, a_op2, b_op1, b_op2;
  wire [1:0]       a_src, b_src;
  wire [15:0]      a_cnt;
  wire [1:0]       b_cnt;
  wire             a_ack0, a_ack1, a_ack2, a_ack3, b_ack0, b_ack1, b_ack2, b_ack3;
  int              checks = 0;
  int              failures = 0;
  bit              m_busy = 0;
  int              m_src = 0;
  logic [XLEN-1:0] m_op1 = '0, m_op2 = '0;
  int              m_hs = 0;
  logic [3:0]      got_ack = '0;
  bit              did_reset = 0;

  always #5 clk = ~clk;

  lnrv_exu_flush_arb #(.XLEN(XLEN), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n),
    .dbg_flush_req(req[0]), .dbg_flush_pc_op1(op1[0]), .dbg_flush_pc_op2(op2[0]), .dbg_flush_ack(a_ack0),
    .exc_flush_req(req[1]), .exc_flush_pc_op1(op1[1]), .exc_flush_pc_op2(op2[1]), .exc_flush_ack(a_ack1),
    .irq_flush_req(req[2]), .irq_flush_pc_op1(op1[2]), .irq_flush_pc_op2(op2[2]), .irq_flush_ack(a_ack2),
    .bjp_flush_req(req[3]), .bjp_flush_pc_op1(op1[3]), .bjp_flush_pc_op2(op2[3]), .bjp_flush_ack(a_ack3),
    .pipe_flush_req(a_preq), .pipe_flush_ack(pack), .pipe_flush_pc_op1(a_op1), .pipe_flush_pc_op2(a_op2),
    .pipe_flush_src(a_src), .flush_busy(a_busy), .flush_cnt(a_cnt));

  lnrv_exu_flush_arb #(.XLEN(XLEN), .CNT_W(2)) u_b (
    .clk(clk), .reset_n(reset_n),
    .dbg_flush_req(req[0]), .dbg_flush_pc_op1(op1[0]), .dbg_flush_pc_op2(op2[0]), .dbg_flush_ack(b_ack0),
    .exc_flush_req(req[1]), .exc_flush_pc_op1(op1[1]), .exc_flush_pc_op2(op2[1]), .exc_flush_ack(b_ack1),
    .irq_flush_req(req[2]), .irq_flush_pc_op1(op1[2]), .irq_flush_pc_op2(op2[2]), .irq_flush_ack(b_ack2),
    .bjp_flush_req(req[3]), .bjp_flush_pc_op1(op1[3]), .bjp_flush_pc_op2(op2[3]), .bjp_flush_ack(b_ack3),
    .pipe_flush_req(b_preq), .pipe_flush_ack(pack), .pipe_flush_pc_op1(b_op1), .pipe_flush_pc_op2(b_op2),
    .pipe_flush_src(b_src), .flush_busy(b_busy), .flush_cnt(b_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      if (req[k] && got_ack[k]) req[k] = 1'b0;
      else if (!req[k]) begin
        if ($urandom_range(3) == 0) begin
          req[k] = 1'b1;
          op1[k] = $urandom;
          op2[k] = $urandom;
        end
      end else begin
        if ($urandom_range(7) == 0) op1[k] = $urandom;
        if ($urandom_range(7) == 0) op2[k] = $urandom;
        if ($urandom_range(15) == 0) req[k] = 1'b0;
      end
    end
    pack = $urandom_range(1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_preq"}, a_preq, 0);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_cnt"}, a_cnt, 0);
    chk({tag, "_acks"}, {a_ack3, a_ack2, a_ack1, a_ack0}, 0);
    chk({tag, "_b_cnt"}, b_cnt, 0);
    chk({tag, "_b_preq"}, b_preq, 0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      op1[k] = '0;
      op2[k] = '0;
    end
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (i >= 1500 && !did_reset && m_busy) begin
        did_reset = 1;
        pack = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        #2 reset_n = 1'b1;
        req = '0;
        pack = 1'b0;
        got_ack = '0;
        m_busy = 0;
        m_hs = 0;
        continue;
      end
      drive();
      @(negedge clk);
      got_ack = (m_busy && pack) ? 4'(1 << m_src) : 4'b0;
      chk("preq", a_preq, m_busy);
      chk("busy", a_busy, m_busy);
      chk("acks", {a_ack3, a_ack2, a_ack1, a_ack0}, got_ack);
      chk("b_acks", {b_ack3, b_ack2, b_ack1, b_ack0}, got_ack);
      chk("cnt", a_cnt, m_hs);
      chk("sat_cnt", b_cnt, (m_hs > 3) ? 3 : m_hs);
      if (m_busy) begin
        chk("src", a_src, m_src);
        chk("op1", a_op1, m_op1);
        chk("op2", a_op2, m_op2);
        chk("b_op1", b_op1, m_op1);
      end
      if (m_busy) begin
        if (pack) begin
          m_busy = 0;
          m_hs++;
        end
      end else if (req != 0) begin
        m_busy = 1;
        m_src = 0;
        while (!req[m_src]) m_src++;
        m_op1 = op1[m_src];
        m_op2 = op2[m_src];
      end
    end
    chk("reset_exercised", did_reset, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
